// File: rtl/mikroprocesor_pkg.sv
// Shared microprocessor definitions: default bus widths and the PC sequencer state encoding.
package mikroprocesor_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALL_LO = 3'd1,
    CALL_HI = 3'd2,
    RET_HI  = 3'd3,
    RET_LO  = 3'd4,
    ERR     = 3'd5
  } lr_state_e;

endpackage

// File: rtl/licznik_rozkazow.sv
// Program counter with call/return through an external byte-wide stack; one byte moved per cycle.
// Optional call-depth counter output enabled by defining LICZNIK_CALL_DEPTH_EN.
module licznik_rozkazow
  import mikroprocesor_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DATA_W   = DATA_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_addr,
  input  logic              call,
  input  logic [PC_W-1:0]   call_addr,
  input  logic              ret,
  input  logic              err_clr,
  input  logic              stk_full,
  input  logic              stk_empty,
  input  logic [DATA_W-1:0] stk_rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_unf
`ifdef LICZNIK_CALL_DEPTH_EN
  , output logic [DEPTH_W-1:0] call_depth
`endif
);

  lr_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ret_addr_q, ret_addr_d;
  logic [PC_W-1:0]   call_addr_q, call_addr_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ret_addr_d  = ret_addr_q;
    call_addr_d = call_addr_q;
    hi_d        = hi_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;
    case (state_q)
      IDLE: begin
        // ret > call > jmp > en; losers are dropped, not queued.
        if (ret) begin
          state_d = RET_HI;
        end else if (call) begin
          ret_addr_d  = pc_q + PC_W'(1);
          call_addr_d = call_addr;
          state_d     = CALL_LO;
        end else if (jmp) begin
          pc_d = jmp_addr;
        end else if (en) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      CALL_LO: begin
        if (stk_full) begin
          err_ovf_d = 1'b1;
          state_d   = ERR;
        end else begin
          state_d = CALL_HI;
        end
      end
      CALL_HI: begin
        if (stk_full) begin
          err_ovf_d = 1'b1;
          state_d   = ERR;
        end else begin
          pc_d    = call_addr_q;
          state_d = IDLE;
        end
      end
      RET_HI: begin
        if (stk_empty) begin
          err_unf_d = 1'b1;
          state_d   = ERR;
        end else begin
          hi_d    = stk_rdata;
          state_d = RET_LO;
        end
      end
      RET_LO: begin
        if (stk_empty) begin
          err_unf_d = 1'b1;
          state_d   = ERR;
        end else begin
          pc_d    = {hi_q, stk_rdata};
          state_d = IDLE;
        end
      end
      ERR: begin
        if (err_clr) begin
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ret_addr_q  <= '0;
      call_addr_q <= '0;
      hi_q        <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_addr_q  <= ret_addr_d;
      call_addr_q <= call_addr_d;
      hi_q        <= hi_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  // Low byte goes on the stack first so the return pops the high byte first.
  always_comb begin
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
    case (state_q)
      CALL_LO: begin
        stk_push  = !stk_full;
        stk_wdata = stk_full ? '0 : ret_addr_q[DATA_W-1:0];
      end
      CALL_HI: begin
        stk_push  = !stk_full;
        stk_wdata = stk_full ? '0 : ret_addr_q[PC_W-1:DATA_W];
      end
      RET_HI, RET_LO: stk_pop = !stk_empty;
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign busy    = (state_q != IDLE);
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

`ifdef LICZNIK_CALL_DEPTH_EN
  logic [DEPTH_W-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (state_q == CALL_HI && !stk_full && depth_q != '1) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (state_q == RET_LO && !stk_empty && depth_q != '0) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) depth_q <= '0;
    else      depth_q <= depth_d;
  end

  assign call_depth = depth_q;
`endif

endmodule

// File: tb/tb_licznik_rozkazow.sv
// Directed bench for licznik_rozkazow: vector table for single-cycle commands plus call/return/error sequences.
module tb_licznik_rozkazow;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, jmp, call, ret, err_clr;
  logic [15:0] jmp_addr, call_addr;
  logic        stk_full, stk_empty;
  logic [7:0]  stk_rdata;
  logic        stk_push, stk_pop;
  logic [7:0]  stk_wdata;
  logic [15:0] pc;
  logic        busy, err_ovf, err_unf;
`ifdef LICZNIK_CALL_DEPTH_EN
  logic [4:0]  call_depth;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  licznik_rozkazow #(
    .PC_W(16), .DATA_W(8), .RESET_PC(16'h0100), .DEPTH_W(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr),
    .call(call), .call_addr(call_addr), .ret(ret), .err_clr(err_clr),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_rdata(stk_rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .pc(pc), .busy(busy), .err_ovf(err_ovf), .err_unf(err_unf)
`ifdef LICZNIK_CALL_DEPTH_EN
    , .call_depth(call_depth)
`endif
  );

  typedef struct {
    logic        en, jmp, call, ret;
    logic [15:0] jmp_addr;
    logic [15:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; jmp = 0; call = 0; ret = 0; err_clr = 0;
    jmp_addr = '0; call_addr = '0;
  endtask

  // Full call with a non-full stack; checks both pushed bytes and the landing pc.
  task automatic do_call(input logic [15:0] target, input logic [15:0] from_pc);
    logic [15:0] ra;
    ra = from_pc + 16'd1;
    call = 1; call_addr = target;
    step();
    call = 0; call_addr = '0;
    #1;
    chk("call_lo_push", stk_push, 1);
    chk("call_lo_wdata", stk_wdata, ra[7:0]);
    chk("call_lo_busy", busy, 1);
    step();
    chk("call_hi_push", stk_push, 1);
    chk("call_hi_wdata", stk_wdata, ra[15:8]);
    step();
    chk("call_pc", pc, target);
    chk("call_done_busy", busy, 0);
    chk("call_done_push", stk_push, 0);
  endtask

  // Full return, stack supplying hi then lo.
  task automatic do_ret(input logic [7:0] hi, input logic [7:0] lo);
    ret = 1;
    step();
    ret = 0;
    stk_rdata = hi;
    #1;
    chk("ret_hi_pop", stk_pop, 1);
    chk("ret_hi_push", stk_push, 0);
    step();
    stk_rdata = lo;
    #1;
    chk("ret_lo_pop", stk_pop, 1);
    step();
    stk_rdata = '0;
    chk("ret_pc", pc, {hi, lo});
    chk("ret_done_busy", busy, 0);
    chk("ret_done_pop", stk_pop, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0101, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0103, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0103, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hABCD, 16'hABCD, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h12FF, 16'h12FF, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h12FF, 1'b0};

    idle_inputs();
    stk_full = 0; stk_empty = 1; stk_rdata = '0;
    rst = 0;
    #12;
    chk("rst_pc", pc, 16'h0100);
    chk("rst_busy", busy, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_errs", {err_ovf, err_unf}, 0);
`ifdef LICZNIK_CALL_DEPTH_EN
    chk("rst_depth", call_depth, 0);
`endif
    @(negedge clk);
    rst = 1;
    step();

    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; jmp = vecs[i].jmp; call = vecs[i].call; ret = vecs[i].ret;
      jmp_addr = vecs[i].jmp_addr;
      step();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end
    idle_inputs();

    // Call from 0x12FF: pushes 0x00 then 0x13, lands on 0x4000; return pops 0x13, 0x00.
    stk_empty = 0;
    do_call(16'h4000, 16'h12FF);
    do_ret(8'h13, 8'h00);

    // Underflow: empty stack on return.
    stk_empty = 1;
    ret = 1;
    step();
    ret = 0;
    #1;
    chk("unf_no_pop", stk_pop, 0);
    step();
    chk("unf_flag", err_unf, 1);
    chk("unf_pc", pc, 16'h1300);
    chk("unf_busy", busy, 1);
    en = 1; jmp = 1; jmp_addr = 16'h7777;
    step();
    en = 0; jmp = 0;
    chk("unf_hold_pc", pc, 16'h1300);
    chk("unf_hold_flag", err_unf, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("unf_clr_flag", err_unf, 0);
    chk("unf_clr_busy", busy, 0);
    // err_clr outside ERR is harmless.
    err_clr = 1; en = 1;
    step();
    err_clr = 0; en = 0;
    chk("clr_idle_pc", pc, 16'h1301);

    // Overflow: stack becomes full during the high-byte push.
    stk_empty = 0;
    call = 1; call_addr = 16'h2000;
    step();
    call = 0;
    #1;
    chk("ovf_first_push", stk_push, 1);
    step();
    stk_full = 1;
    #1;
    chk("ovf_second_push", stk_push, 0);
    chk("ovf_wdata_zero", stk_wdata, 0);
    step();
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_pc", pc, 16'h1301);
    chk("ovf_busy", busy, 1);
    step();
    chk("ovf_busy_hold", busy, 1);
    stk_full = 0;
    err_clr = 1;
    step();
    err_clr = 0;
    chk("ovf_clr_flag", err_ovf, 0);
    chk("ovf_clr_busy", busy, 0);

    // All commands at once: return wins; commands while busy are ignored.
    en = 1; jmp = 1; jmp_addr = 16'h5555; call = 1; call_addr = 16'h6666; ret = 1;
    step();
    ret = 0;
    stk_rdata = 8'hAB;
    #1;
    chk("prio_pop", stk_pop, 1);
    chk("prio_no_push", stk_push, 0);
    step();
    stk_rdata = 8'hCD;
    #1;
    chk("busy_ign_pop", stk_pop, 1);
    step();
    idle_inputs();
    stk_rdata = '0;
    chk("prio_pc", pc, 16'hABCD);
    chk("prio_busy", busy, 0);

    // Reset in the middle of a call abandons it.
    do_call(16'h0800, 16'hABCD);
    call = 1; call_addr = 16'h0900;
    step();
    call = 0;
    rst = 0;
    #1;
    chk("midrst_push", stk_push, 0);
    chk("midrst_pc", pc, 16'h0100);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    step();

`ifdef LICZNIK_CALL_DEPTH_EN
    do_call(16'h0200, 16'h0100);
    do_call(16'h0300, 16'h0200);
    chk("depth_two", call_depth, 2);
    do_ret(8'h02, 8'h01);
    do_ret(8'h01, 8'h01);
    chk("depth_zero", call_depth, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
